// File: rtl/pwm_gen_if.sv
// rtl/pwm_gen_if.sv - configuration handshake bundle for pwm_gen
interface pwm_gen_if #(
  parameter int WIDTH = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - tick-driven PWM generator with shadowed period/duty
module pwm_gen #(
  parameter int WIDTH = 8
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_tick_clk,
  input  logic     i_en,
  pwm_gen_if.slave cfg,
  output logic     o_pwm,
  output logic     o_period_done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             tick_prev;
  logic             tick;
  logic             pending;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] shadow_period;
  logic [WIDTH-1:0] shadow_duty;
  logic [WIDTH-1:0] act_period;
  logic [WIDTH-1:0] act_duty;
  logic             cfg_xfer;
  logic             at_boundary;
  logic             load_active;
  logic             pwm_nxt;
  logic             done_nxt;

  // A tick is the first cycle the divided clock is seen high.
  assign tick        = i_tick_clk & ~tick_prev;
  // The shadow register accepts a new offer only once the previous one has been consumed.
  assign cfg.cfg_ready = ~pending;
  assign cfg_xfer    = cfg.cfg_valid & ~pending;
  // Last tick of the period while running; dropping i_en discards the partial period.
  assign at_boundary = (state == RUN) & i_en & tick & (cnt == act_period);
  // Shadow is promoted straight away while idle, otherwise only on a period boundary.
  assign load_active = pending & ((state == IDLE) | at_boundary);

  // Remember last sample of the divided clock for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_prev <= 1'b0;
    end else begin
      tick_prev <= i_tick_clk;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: run enable alone moves between IDLE and RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_en)  state_nxt = RUN;
      RUN:     if (!i_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tick counter next value: cleared outside RUN, wraps only at the active period.
  always_comb begin
    cnt_nxt = cnt;
    if ((state != RUN) || !i_en) begin
      cnt_nxt = '0;
    end else if (tick) begin
      if (cnt == act_period) begin
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Tick counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // FSM outputs: duty compare against the current count, done on the boundary.
  always_comb begin
    pwm_nxt  = (state == RUN) & i_en & (cnt < act_duty);
    done_nxt = at_boundary;
  end

  // Register outputs so the waveform is glitch-free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pwm         <= 1'b0;
      o_period_done <= 1'b0;
    end else begin
      o_pwm         <= pwm_nxt;
      o_period_done <= done_nxt;
    end
  end

  // Config path: capture into shadow on handshake, promote to active when allowed.
  // Capture needs pending low and promotion needs it high, so they never coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending       <= 1'b0;
      shadow_period <= '0;
      shadow_duty   <= '0;
      act_period    <= '1;
      act_duty      <= '0;
    end else if (load_active) begin
      act_period <= shadow_period;
      act_duty   <= shadow_duty;
      pending    <= 1'b0;
    end else if (cfg_xfer) begin
      shadow_period <= cfg.cfg_period;
      shadow_duty   <= cfg.cfg_duty;
      pending       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen
module tb_pwm_gen;

  logic clk;
  logic rst_n;
  logic tick_clk;
  logic en;
  logic pwm;
  logic period_done;

  pwm_gen_if #(.WIDTH(8)) cfg_bus ();

  pwm_gen #(.WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_tick_clk   (tick_clk),
    .i_en         (en),
    .cfg          (cfg_bus.slave),
    .o_pwm        (pwm),
    .o_period_done(period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p;
    int d;
    int exp_high;
    int exp_len;
  } vec_t;

  vec_t vecs[10];

  int tests_run;
  int tests_failed;
  int tick_ctr;
  bit prev_tick;
  bit last_tick;
  bit last_xfer;
  bit win_valid;
  int win_high;
  int win_len;
  int last_high;
  int last_len;
  int done_count;
  bit model_check;
  bit suppress_ready;
  int m_p;
  int m_d;
  bit m_pend;
  int pend_p;
  int pend_d;

  task automatic check(string name, int act, int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic int exp_high_of(int p, int d);
    return 8 * ((d < p + 1) ? d : p + 1);
  endfunction

  task automatic model_reset();
    m_p       = 255;
    m_d       = 0;
    m_pend    = 1'b0;
    win_valid = 1'b0;
    prev_tick = 1'b0;
  endtask

  // One clock: drive the divided clock, cross the edge, sample, update the period-level model.
  task automatic step();
    int pv;
    int dv;
    bit xf;
    tick_ctr++;
    tick_clk  = ((tick_ctr >> 2) & 1) != 0;
    last_tick = tick_clk & ~prev_tick;
    prev_tick = tick_clk;
    xf = cfg_bus.cfg_valid & cfg_bus.cfg_ready;
    pv = int'(cfg_bus.cfg_period);
    dv = int'(cfg_bus.cfg_duty);
    @(posedge clk);
    #1;
    last_xfer = xf;
    if (win_valid) begin
      win_len++;
      if (pwm) win_high++;
    end
    if (period_done) begin
      done_count++;
      if (win_valid) begin
        last_high = win_high;
        last_len  = win_len;
        if (model_check) begin
          check("win_high", win_high, exp_high_of(m_p, m_d));
          check("win_len", win_len, 8 * (m_p + 1));
        end
      end
      if (m_pend) begin
        m_p    = pend_p;
        m_d    = pend_d;
        m_pend = 1'b0;
      end
      win_valid = 1'b1;
      win_high  = 0;
      win_len   = 0;
    end
    if (xf) begin
      m_pend = 1'b1;
      pend_p = pv;
      pend_d = dv;
    end
    if (model_check && !suppress_ready)
      check("cfg_ready", int'(cfg_bus.cfg_ready), m_pend ? 0 : 1);
  endtask

  task automatic offer(int p, int d);
    bit ok;
    ok = 1'b0;
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_period = 8'(p);
    cfg_bus.cfg_duty   = 8'(d);
    for (int k = 0; k < 600; k++) begin
      step();
      if (last_xfer) begin
        ok = 1'b1;
        break;
      end
    end
    cfg_bus.cfg_valid = 1'b0;
    if (!ok) timeout_fail("cfg_handshake");
  endtask

  task automatic wait_dones(int n);
    int target;
    target = done_count + n;
    for (int k = 0; k < 3000; k++) begin
      if (done_count >= target) break;
      step();
    end
    if (done_count < target) timeout_fail("period_done");
  endtask

  // Idle long enough for a pending config to be adopted, then model that adoption.
  task automatic idle(int n);
    en             = 1'b0;
    win_valid      = 1'b0;
    suppress_ready = 1'b1;
    repeat (n) step();
    if (m_pend) begin
      m_p    = pend_p;
      m_d    = pend_d;
      m_pend = 1'b0;
    end
    suppress_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int ticks;
    int dc0;
    int hi;

    vecs[0] = '{p: 3, d: 1,   exp_high: 8,  exp_len: 32};
    vecs[1] = '{p: 3, d: 3,   exp_high: 24, exp_len: 32};
    vecs[2] = '{p: 3, d: 0,   exp_high: 0,  exp_len: 32};
    vecs[3] = '{p: 3, d: 5,   exp_high: 32, exp_len: 32};
    vecs[4] = '{p: 0, d: 0,   exp_high: 0,  exp_len: 8};
    vecs[5] = '{p: 0, d: 1,   exp_high: 8,  exp_len: 8};
    vecs[6] = '{p: 2, d: 3,   exp_high: 24, exp_len: 24};
    vecs[7] = '{p: 7, d: 4,   exp_high: 32, exp_len: 64};
    vecs[8] = '{p: 7, d: 8,   exp_high: 64, exp_len: 64};
    vecs[9] = '{p: 1, d: 255, exp_high: 16, exp_len: 16};

    tests_run      = 0;
    tests_failed   = 0;
    tick_ctr       = 0;
    done_count     = 0;
    last_high      = 0;
    last_len       = 0;
    win_high       = 0;
    win_len        = 0;
    last_tick      = 1'b0;
    last_xfer      = 1'b0;
    model_check    = 1'b0;
    suppress_ready = 1'b0;
    pend_p         = 0;
    pend_d         = 0;
    model_reset();

    rst_n              = 1'b0;
    en                 = 1'b0;
    tick_clk           = 1'b0;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_period = 8'd0;
    cfg_bus.cfg_duty   = 8'd0;

    // Reset state
    repeat (2) step();
    check("reset_pwm", int'(pwm), 0);
    check("reset_ready", int'(cfg_bus.cfg_ready), 1);
    check("reset_done", int'(period_done), 0);
    rst_n = 1'b1;
    model_reset();

    // Load P=3 D=1 while idle, then run
    offer(3, 1);
    idle(3);
    en = 1'b1;

    // Table-driven period/duty vectors, each loaded mid-run
    foreach (vecs[i]) begin
      offer(vecs[i].p, vecs[i].d);
      wait_dones(2);
      check($sformatf("vec%0d_high", i), last_high, vecs[i].exp_high);
      check($sformatf("vec%0d_len", i), last_len, vecs[i].exp_len);
    end

    // Mid-period reload: ready stays low until the boundary, new duty next period
    offer(3, 1);
    wait_dones(2);
    repeat (12) step();
    offer(3, 3);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (period_done) break;
      if (cfg_bus.cfg_ready !== 1'b0) bad++;
    end
    check("ready_low_until_boundary", bad, 0);
    check("ready_at_boundary", int'(cfg_bus.cfg_ready), 1);
    wait_dones(1);
    check("reload_high", last_high, 24);
    check("reload_len", last_len, 32);

    // Drop enable at count 2 of 4, then restart from zero
    wait_dones(1);
    repeat (18) step();
    check("pwm_before_drop", int'(pwm), 1);
    en        = 1'b0;
    win_valid = 1'b0;
    step();
    check("pwm_after_drop", int'(pwm), 0);
    dc0 = done_count;
    repeat (40) step();
    check("no_done_while_disabled", done_count - dc0, 0);
    en = 1'b1;
    step();
    ticks = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (last_tick) ticks++;
      if (period_done) break;
    end
    check("restart_ticks_to_done", ticks, 4);

    // Handshake on the exact boundary cycle loads one period later
    offer(3, 1);
    wait_dones(2);
    repeat (31) step();
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_period = 8'd3;
    cfg_bus.cfg_duty   = 8'd2;
    step();
    cfg_bus.cfg_valid = 1'b0;
    check("boundary_done", int'(period_done), 1);
    check("boundary_xfer", int'(last_xfer), 1);
    wait_dones(1);
    check("boundary_old_high", last_high, 8);
    wait_dones(1);
    check("boundary_new_high", last_high, 16);
    check("boundary_new_len", last_len, 32);

    // Asynchronous reset mid-run with a config pending
    offer(3, 5);
    wait_dones(2);
    check("const_high_pwm", int'(pwm), 1);
    offer(2, 0);
    check("pending_ready_low", int'(cfg_bus.cfg_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm), 0);
    check("async_reset_ready", int'(cfg_bus.cfg_ready), 1);
    check("async_reset_done", int'(period_done), 0);
    repeat (2) step();
    rst_n = 1'b1;
    model_reset();
    hi  = 0;
    dc0 = done_count;
    repeat (40) begin
      step();
      if (pwm) hi++;
    end
    check("post_reset_pwm_low", hi, 0);
    check("post_reset_no_done", done_count - dc0, 0);
    check("post_reset_ready", int'(cfg_bus.cfg_ready), 1);

    // Randomized reloads and enable drops against the period-level model
    en = 1'b0;
    offer(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
    idle(4);
    en          = 1'b1;
    model_check = 1'b1;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(int'($urandom_range(3, 10)));
        en = 1'b1;
      end else begin
        repeat ($urandom_range(0, 40)) step();
        offer(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
      end
    end
    wait_dones(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
